systolic_ctrl: RTL and testbench

//  Sequencer for a ROWS x COLS systolic array of MAC cells with pass-through data/weight paths.
//  On a start command it performs these steps in order:
//   - clears the array
//   - issues K operand-buffer reads
//   - generates the per-row/per-column skewed feed enables
//   - waits for the wavefront to drain
//   - hands the COLS result columns out over a valid/ready port

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/systolic_ctrl_skew_shift.sv | 33 +++
 rtl/systolic_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types, default geometry and width helpers for the systolic array sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int ROWS_DEF    = 4;
  localparam int COLS_DEF    = 4;
  localparam int K_MAX_DEF   = 256;
  localparam int RD_LAT_DEF  = 1;
  localparam int K_W_DEF     = $clog2(K_MAX_DEF + 1);
  localparam int ADDR_W_DEF  = $clog2(K_MAX_DEF);
  localparam int COL_W_DEF   = $clog2(COLS_DEF);

  // Cycles for the last operand to clear the read pipe and the full row+column skew.
  function automatic int drain_cycles(input int rd_lat, input int rows, input int cols);
    return rd_lat + rows + cols - 1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_shift.sv
// 1-bit serial delay line; tap i is the input delayed by i cycles (tap 0 is the input itself).
module skew_shift #(
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_d,
  output logic [DEPTH-1:0] o_taps
);

  generate
    if (DEPTH > 1) begin : g_shift
      logic [DEPTH-1:1] r_sh;

      // Serial shift of the feed strobe, one stage per tap.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_sh <= '0;
        end else begin
          r_sh[1] <= i_d;
          for (int i = 2; i < DEPTH; i++) begin
            r_sh[i] <= r_sh[i-1];
          end
        end
      end

      assign o_taps = {r_sh, i_d};
    end else begin : g_single
      assign o_taps = i_d;
    end
  endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for a ROWS x COLS systolic MAC array: clear, operand reads,
// skewed feed enables, wavefront drain and result-column handout.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int K_MAX  = K_MAX_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] k_len,
  output logic                       busy,
  output logic                       done,
  output logic                       array_clr,
  output logic                       rd_en,
  output logic [$clog2(K_MAX)-1:0]   rd_addr,
  output logic [ROWS-1:0]            row_en,
  output logic [COLS-1:0]            col_en,
  output logic                       out_valid,
  output logic [$clog2(COLS)-1:0]    out_col,
  input  logic                       out_ready
);

  localparam int K_W       = $clog2(K_MAX + 1);
  localparam int A_W       = $clog2(K_MAX);
  localparam int C_W       = $clog2(COLS);
  localparam int DRAIN_CYC = drain_cycles(RD_LAT, ROWS, COLS);
  localparam int D_W       = $clog2(DRAIN_CYC + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [K_W-1:0]   r_klen;
  logic [K_W-1:0]   r_k;
  logic [K_W-1:0]   w_k_clamp;
  logic [D_W-1:0]   r_drn;
  logic [C_W-1:0]   r_col;
  logic             r_busy;
  logic             r_done;
  logic             r_clr;
  logic             r_rd_en;
  logic             r_valid;
  logic [RD_LAT-1:0] r_lat;
  logic             w_feed_v;
  logic             w_hs;

  // Oversized reduction lengths saturate at the buffer depth.
  always_comb begin
    w_k_clamp = k_len;
    if (k_len > K_W'(K_MAX)) begin
      w_k_clamp = K_W'(K_MAX);
    end else begin
      w_k_clamp = k_len;
    end
  end

  assign w_hs = r_valid & out_ready;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_k_clamp == K_W'(0)) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = CLEAR;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CLEAR: w_state_nxt = FEED;
      FEED: begin
        if (r_k == r_klen - K_W'(1)) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = FEED;
        end
      end
      DRAIN: begin
        if (r_drn == D_W'(DRAIN_CYC - 1)) begin
          w_state_nxt = OUTPUT;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      OUTPUT: begin
        if (w_hs && (r_col == C_W'(COLS - 1))) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = OUTPUT;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Job length latch plus k, drain and column counters; each idles at zero outside its phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_klen <= '0;
      r_k    <= '0;
      r_drn  <= '0;
      r_col  <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_klen <= w_k_clamp;
      end else begin
        r_klen <= r_klen;
      end
      if ((r_state == FEED) && (w_state_nxt == FEED)) begin
        r_k <= r_k + K_W'(1);
      end else begin
        r_k <= '0;
      end
      if ((r_state == DRAIN) && (w_state_nxt == DRAIN)) begin
        r_drn <= r_drn + D_W'(1);
      end else begin
        r_drn <= '0;
      end
      if (w_state_nxt != OUTPUT) begin
        r_col <= '0;
      end else if (w_hs) begin
        r_col <= r_col + C_W'(1);
      end else begin
        r_col <= r_col;
      end
    end
  end

  // Control strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clr   <= 1'b0;
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
      r_done  <= (w_state_nxt == DONE);
      r_clr   <= (w_state_nxt == CLEAR);
      r_rd_en <= (w_state_nxt == FEED);
      r_valid <= (w_state_nxt == OUTPUT);
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      // Operand-buffer read latency of one cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_lat <= '0;
        end else begin
          r_lat <= r_rd_en;
        end
      end
    end else begin : g_latn
      // Operand-buffer read latency pipe.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_lat <= '0;
        end else begin
          r_lat <= {r_lat[RD_LAT-2:0], r_rd_en};
        end
      end
    end
  endgenerate

  assign w_feed_v = r_lat[RD_LAT-1];

  skew_shift #(.DEPTH(ROWS)) u_row_skew (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (w_feed_v),
    .o_taps  (row_en)
  );

  skew_shift #(.DEPTH(COLS)) u_col_skew (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (w_feed_v),
    .o_taps  (col_en)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign array_clr = r_clr;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_k[A_W-1:0];
  assign out_valid = r_valid;
  assign out_col   = r_col;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: fixed timing table, corner sequences and
// randomized traffic checked against a cycle-schedule reference model.
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int ROWS   = ROWS_DEF;
  localparam int COLS   = COLS_DEF;
  localparam int K_MAX  = K_MAX_DEF;
  localparam int RD_LAT = RD_LAT_DEF;
  localparam int DRN    = drain_cycles(RD_LAT, ROWS, COLS);
  localparam int NTAB   = 20;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [K_W_DEF-1:0]    k_len;
  logic                  busy;
  logic                  done;
  logic                  array_clr;
  logic                  rd_en;
  logic [ADDR_W_DEF-1:0] rd_addr;
  logic [ROWS-1:0]       row_en;
  logic [COLS-1:0]       col_en;
  logic                  out_valid;
  logic [COL_W_DEF-1:0]  out_col;
  logic                  out_ready;

  always #5 clk = ~clk;

  systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .array_clr(array_clr), .rd_en(rd_en), .rd_addr(rd_addr), .row_en(row_en),
    .col_en(col_en), .out_valid(out_valid), .out_col(out_col), .out_ready(out_ready)
  );

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  clr;
    logic                  rd_en;
    logic [ADDR_W_DEF-1:0] addr;
    logic [ROWS-1:0]       row;
    logic [COLS-1:0]       col;
    logic                  valid;
    logic [COL_W_DEF-1:0]  ocol;
  } obs_t;

  typedef struct packed {
    logic               start;
    logic [K_W_DEF-1:0] k_len;
    logic               ready;
    obs_t               exp;
  } vec_t;

  vec_t tab [NTAB];

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  bit   m_active;
  int   m_t;
  int   m_k;
  int   m_beats;
  obs_t m_exp;

  function automatic obs_t sample();
    obs_t o;
    o.busy  = busy;
    o.done  = done;
    o.clr   = array_clr;
    o.rd_en = rd_en;
    o.addr  = rd_addr;
    o.row   = row_en;
    o.col   = col_en;
    o.valid = out_valid;
    o.ocol  = out_col;
    return o;
  endfunction

  function automatic obs_t masked(obs_t v, obs_t r);
    obs_t o = v;
    if (!r.rd_en) o.addr = '0;
    if (!r.valid) o.ocol = '0;
    return o;
  endfunction

  task automatic chk_obs(input string nm, input obs_t exp, input bit strict);
    obs_t act;
    obs_t e;
    act = strict ? sample() : masked(sample(), exp);
    e   = strict ? exp : masked(exp, exp);
    n_checks++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, e);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Expected outputs from the job schedule: relative cycle, length and beats taken so far.
  function automatic obs_t model_out();
    obs_t o = '0;
    bit   fin;
    if (m_active) begin
      fin = (m_k == 0) ? (m_t == 1) : (m_beats == COLS);
      if (fin) begin
        o.done = 1'b1;
      end else begin
        o.busy  = 1'b1;
        o.clr   = (m_t == 1);
        o.rd_en = (m_t >= 2) && (m_t <= m_k + 1);
        if (o.rd_en) o.addr = ADDR_W_DEF'(m_t - 2);
        for (int r = 0; r < ROWS; r++)
          o.row[r] = (m_t >= 2 + RD_LAT + r) && (m_t <= m_k + 1 + RD_LAT + r);
        for (int c = 0; c < COLS; c++)
          o.col[c] = (m_t >= 2 + RD_LAT + c) && (m_t <= m_k + 1 + RD_LAT + c);
        o.valid = (m_t >= m_k + 2 + DRN);
        if (o.valid) o.ocol = COL_W_DEF'(m_beats);
      end
    end
    return o;
  endfunction

  function automatic void model_adv(input bit st, input int kl, input bit rdy, input bit rs,
                                    input obs_t prev);
    if (rs) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_t      = 1;
        m_k      = (kl > K_MAX) ? K_MAX : kl;
        m_beats  = 0;
      end
    end else if (prev.done) begin
      m_active = 1'b0;
    end else begin
      if (prev.valid && rdy) m_beats++;
      m_t++;
    end
  endfunction

  task automatic step(input bit st, input int kl, input bit rdy, input bit rs);
    obs_t prev;
    prev      = m_exp;
    reset     = rs;
    start     = st;
    k_len     = K_W_DEF'(kl);
    out_ready = rdy;
    @(posedge clk);
    #1;
    cyc++;
    model_adv(st, kl, rdy, rs, prev);
    m_exp = model_out();
    chk_obs("model", m_exp, 1'b0);
  endtask

  // Literal T1/T2 timing: k_len=4 at c0, out_ready held high.
  function automatic void fill_table();
    for (int c = 0; c < NTAB; c++) begin
      tab[c]           = '0;
      tab[c].start     = (c == 0);
      tab[c].k_len     = K_W_DEF'(4);
      tab[c].ready     = 1'b1;
      tab[c].exp.busy  = (c >= 1) && (c <= 17);
      tab[c].exp.done  = (c == 18);
      tab[c].exp.clr   = (c == 1);
      tab[c].exp.rd_en = (c >= 2) && (c <= 5);
      if (tab[c].exp.rd_en) tab[c].exp.addr = ADDR_W_DEF'(c - 2);
      for (int r = 0; r < ROWS; r++) begin
        tab[c].exp.row[r] = (c >= 3 + r) && (c <= 6 + r);
        tab[c].exp.col[r] = (c >= 3 + r) && (c <= 6 + r);
      end
      tab[c].exp.valid = (c >= 14) && (c <= 17);
      if (tab[c].exp.valid) tab[c].exp.ocol = COL_W_DEF'(c - 14);
    end
  endfunction

  task automatic run_table(input string nm);
    for (int i = 0; i < NTAB; i++) begin
      chk_obs(nm, tab[i].exp, 1'b0);
      step(tab[i].start, int'(tab[i].k_len), tab[i].ready, 1'b0);
    end
  endtask

  initial begin
    int done_at;
    int reads;
    int last_addr;
    int clr_q[$];

    m_active = 1'b0;
    m_t = 0; m_k = 0; m_beats = 0;
    m_exp = '0;
    fill_table();

    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 4, 1'b1, 1'b1);
    chk_obs("reset_zero", '0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);

    // T1 / T2
    run_table("t1t2_table");

    // T3 backpressure on the first three output cycles
    done_at = -1;
    for (int c = 0; c < 26; c++) begin
      step(c == 0, 4, !((c >= 14) && (c <= 16)), 1'b0);
      if (done && (done_at < 0)) done_at = c + 1;
    end
    chk_int("t3_done_cycle", done_at, 21);

    // T4 zero-length and clamped jobs
    step(1'b1, 0, 1'b1, 1'b0);
    chk_int("t4_k0_done", int'(done), 1);
    for (int c = 0; c < 4; c++) step(1'b0, 0, 1'b1, 1'b0);
    reads = 0; last_addr = -1; done_at = -1;
    for (int c = 0; c < 400; c++) begin
      step(c == 0, 300, 1'b1, 1'b0);
      if (rd_en) begin
        reads++;
        last_addr = int'(rd_addr);
      end
      if (done) begin
        done_at = c + 1;
        break;
      end
    end
    chk_int("t4_clamp_reads", reads, 256);
    chk_int("t4_clamp_last_addr", last_addr, 255);
    chk_int("t4_clamp_done_cycle", done_at, 270);
    step(1'b0, 0, 1'b1, 1'b0);

    // T5 start held high through FEED, OUTPUT and DONE
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 3, 1'b1, 1'b0);
      if (array_clr) clr_q.push_back(c + 1);
    end
    chk_int("t5_clr_count", clr_q.size(), 2);
    if (clr_q.size() >= 2) begin
      chk_int("t5_first_clr", clr_q[0], 1);
      chk_int("t5_second_clr", clr_q[1], 19);
    end
    for (int c = 0; c < 20; c++) step(1'b0, 0, 1'b1, 1'b0);

    // T6 reset during DRAIN, then a fresh job
    for (int c = 0; c < 8; c++) step(c == 0, 4, 1'b1, 1'b0);
    chk_int("t6_in_drain_busy", int'(busy), 1);
    step(1'b0, 4, 1'b1, 1'b1);
    chk_obs("t6_reset_zero", '0, 1'b1);
    for (int c = 0; c < 12; c++) step(1'b0, 0, 1'b1, 1'b0);
    run_table("t6_fresh_table");

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) == 0,
           ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(0, 12)),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
